// File: rtl/mem_stage_if.sv
// Data-memory req/ack port between the memory stage (master) and data memory (slave).
interface mem_stage_if;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [31:0] dmem_rdata;
  logic        dmem_ack;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_wdata,
    input  dmem_rdata, dmem_ack
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
    output dmem_rdata, dmem_ack
  );
endinterface

// File: rtl/mem_stage.sv
// MIPS memory-access stage: captures execute results, resolves taken branches,
// runs loads/stores over a variable-latency req/ack port and emits one
// registered write-back beat per instruction.
module mem_stage #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid_i,
  output logic        ex_ready_o,
  input  logic        branch_i,
  input  logic        mem_read_i,
  input  logic        mem_write_i,
  input  logic        mem_to_reg_i,
  input  logic        reg_write_i,
  input  logic [31:0] alu_res_i,
  input  logic        alu_zero_i,
  input  logic [31:0] pc_branch_i,
  input  logic [31:0] rt_data_i,
  input  logic [4:0]  write_reg_i,
  mem_stage_if.master dmem,
  output logic        pc_src_o,
  output logic [31:0] pc_target_o,
  output logic        wb_valid_o,
  output logic        wb_reg_write_o,
  output logic [4:0]  wb_write_reg_o,
  output logic [31:0] wb_data_o,
  output logic        mem_err_o
);

  localparam int unsigned CNT_W  = 8;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned REG_W  = 5;

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                we_q, we_d;
  logic                m2r_q, m2r_d;
  logic                rw_q, rw_d;
  logic [REG_W-1:0]    wreg_q, wreg_d;
  logic                ex_ready_q, ex_ready_d;
  logic                req_q, req_d;
  logic                pc_src_q, pc_src_d;
  logic [DATA_W-1:0]   pc_target_q, pc_target_d;
  logic                wb_valid_q, wb_valid_d;
  logic                wb_reg_write_q, wb_reg_write_d;
  logic [REG_W-1:0]    wb_write_reg_q, wb_write_reg_d;
  logic [DATA_W-1:0]   wb_data_q, wb_data_d;
  logic                mem_err_q, mem_err_d;
  logic                is_mem;

  // Memory op only when not a branch; mem_write wins over mem_read.
  assign is_mem = ~branch_i & (mem_read_i | mem_write_i);

  // State and output registers; dmem_req drops asynchronously with rst.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      addr_q         <= '0;
      wdata_q        <= '0;
      we_q           <= 1'b0;
      m2r_q          <= 1'b0;
      rw_q           <= 1'b0;
      wreg_q         <= '0;
      ex_ready_q     <= 1'b1;
      req_q          <= 1'b0;
      pc_src_q       <= 1'b0;
      pc_target_q    <= '0;
      wb_valid_q     <= 1'b0;
      wb_reg_write_q <= 1'b0;
      wb_write_reg_q <= '0;
      wb_data_q      <= '0;
      mem_err_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      addr_q         <= addr_d;
      wdata_q        <= wdata_d;
      we_q           <= we_d;
      m2r_q          <= m2r_d;
      rw_q           <= rw_d;
      wreg_q         <= wreg_d;
      ex_ready_q     <= ex_ready_d;
      req_q          <= req_d;
      pc_src_q       <= pc_src_d;
      pc_target_q    <= pc_target_d;
      wb_valid_q     <= wb_valid_d;
      wb_reg_write_q <= wb_reg_write_d;
      wb_write_reg_q <= wb_write_reg_d;
      wb_data_q      <= wb_data_d;
      mem_err_q      <= mem_err_d;
    end
  end

  // Next-state and write-back decode.
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    addr_d         = addr_q;
    wdata_d        = wdata_q;
    we_d           = we_q;
    m2r_d          = m2r_q;
    rw_d           = rw_q;
    wreg_d         = wreg_q;
    pc_src_d       = 1'b0;
    pc_target_d    = pc_target_q;
    wb_valid_d     = 1'b0;
    wb_reg_write_d = wb_reg_write_q;
    wb_write_reg_d = wb_write_reg_q;
    wb_data_d      = wb_data_q;
    mem_err_d      = 1'b0;

    case (state_q)
      IDLE: begin
        if (ex_valid_i) begin
          if (is_mem) begin
            if (alu_res_i[1:0] != 2'b00) begin
              wb_valid_d     = 1'b1;
              mem_err_d      = 1'b1;
              wb_reg_write_d = 1'b0;
              wb_write_reg_d = write_reg_i;
            end else begin
              addr_d  = {alu_res_i[31:2], 2'b00};
              wdata_d = rt_data_i;
              we_d    = mem_write_i;
              m2r_d   = mem_to_reg_i;
              rw_d    = reg_write_i;
              wreg_d  = write_reg_i;
              cnt_d   = '0;
              state_d = ACCESS;
            end
          end else begin
            wb_valid_d     = 1'b1;
            wb_data_d      = alu_res_i;
            wb_reg_write_d = reg_write_i & ~branch_i;
            wb_write_reg_d = write_reg_i;
            pc_src_d       = branch_i & alu_zero_i;
            pc_target_d    = pc_branch_i;
          end
        end
      end
      ACCESS: begin
        if (dmem.dmem_ack) begin
          wb_valid_d     = 1'b1;
          wb_write_reg_d = wreg_q;
          if (we_q) begin
            wb_reg_write_d = 1'b0;
          end else begin
            wb_data_d      = m2r_q ? dmem.dmem_rdata : addr_q;
            wb_reg_write_d = rw_q;
          end
          state_d = IDLE;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          wb_valid_d     = 1'b1;
          mem_err_d      = 1'b1;
          wb_reg_write_d = 1'b0;
          wb_write_reg_d = wreg_q;
          state_d        = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    // Register 0 is hardwired; never enable a write to it.
    wb_reg_write_d = wb_reg_write_d & (wb_write_reg_d != '0);
    ex_ready_d     = (state_d == IDLE);
    req_d          = (state_d == ACCESS);
  end

  assign ex_ready_o       = ex_ready_q;
  assign dmem.dmem_req    = req_q;
  assign dmem.dmem_we     = we_q;
  assign dmem.dmem_addr   = addr_q;
  assign dmem.dmem_wdata  = wdata_q;
  assign pc_src_o         = pc_src_q;
  assign pc_target_o      = pc_target_q;
  assign wb_valid_o       = wb_valid_q;
  assign wb_reg_write_o   = wb_reg_write_q;
  assign wb_write_reg_o   = wb_write_reg_q;
  assign wb_data_o        = wb_data_q;
  assign mem_err_o        = mem_err_q;

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: vector table of single-cycle instructions plus directed
// memory-access sequences; write-back beats checked against an expected queue.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ex_valid = 1'b0, ex_ready;
  logic        branch = 1'b0, mem_read = 1'b0, mem_write = 1'b0;
  logic        mem_to_reg = 1'b0, reg_write = 1'b0, alu_zero = 1'b0;
  logic [31:0] alu_res = '0, pc_branch = '0, rt_data = '0;
  logic [4:0]  write_reg = '0;
  logic        pc_src, wb_valid, wb_reg_write, mem_err;
  logic [31:0] pc_target, wb_data;
  logic [4:0]  wb_write_reg;

  int checks = 0;
  int errors = 0;

  mem_stage_if bus ();

  mem_stage #(.TIMEOUT(4)) dut (
    .clk            (clk),
    .rst            (rst),
    .ex_valid_i     (ex_valid),
    .ex_ready_o     (ex_ready),
    .branch_i       (branch),
    .mem_read_i     (mem_read),
    .mem_write_i    (mem_write),
    .mem_to_reg_i   (mem_to_reg),
    .reg_write_i    (reg_write),
    .alu_res_i      (alu_res),
    .alu_zero_i     (alu_zero),
    .pc_branch_i    (pc_branch),
    .rt_data_i      (rt_data),
    .write_reg_i    (write_reg),
    .dmem           (bus),
    .pc_src_o       (pc_src),
    .pc_target_o    (pc_target),
    .wb_valid_o     (wb_valid),
    .wb_reg_write_o (wb_reg_write),
    .wb_write_reg_o (wb_write_reg),
    .wb_data_o      (wb_data),
    .mem_err_o      (mem_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rw;
    logic [4:0]  wr;
    logic [31:0] data;
    logic        chk_data;
    logic        err;
  } exp_t;

  typedef struct {
    logic        br, mr, mw, m2r, rw, zero;
    logic [31:0] alu, pcb;
    logic [4:0]  wr;
    exp_t        e;
    logic        e_pcsrc;
  } vec_t;

  exp_t exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic br, input logic mr, input logic mw, input logic m2r,
                       input logic rw, input logic zero, input logic [31:0] alu,
                       input logic [31:0] pcb, input logic [31:0] rt, input logic [4:0] wr);
    ex_valid = 1'b1; branch = br; mem_read = mr; mem_write = mw; mem_to_reg = m2r;
    reg_write = rw; alu_zero = zero; alu_res = alu; pc_branch = pcb; rt_data = rt;
    write_reg = wr;
  endtask

  task automatic push(input logic rw, input logic [4:0] wr, input logic [31:0] data,
                      input logic chk_data, input logic err);
    exp_t e;
    e.rw = rw; e.wr = wr; e.data = data; e.chk_data = chk_data; e.err = err;
    exp_q.push_back(e);
  endtask

  // Write-back monitor: every wb_valid beat must match the oldest expectation.
  always @(negedge clk) begin
    if (!rst && wb_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL wb_unexpected actual=beat reg=%0d data=%h expected=none", wb_write_reg, wb_data);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("wb_reg_write", 32'(wb_reg_write), 32'(e.rw));
        chk("wb_write_reg", 32'(wb_write_reg), 32'(e.wr));
        chk("mem_err", 32'(mem_err), 32'(e.err));
        if (e.chk_data) chk("wb_data", wb_data, e.data);
      end
    end
  end

  vec_t vecs[7];

  initial begin
    // br mr mw m2r rw zero alu pcb wr | rw wr data chk err | pcsrc
    vecs[0] = '{1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,32'h1234,32'h0,5'd5,
                '{1'b1,5'd5,32'h1234,1'b1,1'b0},1'b0};
    vecs[1] = '{1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,32'h55,32'h0,5'd0,
                '{1'b0,5'd0,32'h55,1'b1,1'b0},1'b0};
    vecs[2] = '{1'b1,1'b0,1'b0,1'b0,1'b1,1'b1,32'h0,32'h40,5'd3,
                '{1'b0,5'd3,32'h0,1'b1,1'b0},1'b1};
    vecs[3] = '{1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,32'h7,32'h80,5'd0,
                '{1'b0,5'd0,32'h7,1'b1,1'b0},1'b0};
    vecs[4] = '{1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,32'h102,32'h0,5'd2,
                '{1'b0,5'd2,32'h0,1'b0,1'b1},1'b0};
    vecs[5] = '{1'b0,1'b1,1'b0,1'b1,1'b1,1'b0,32'h201,32'h0,5'd7,
                '{1'b0,5'd7,32'h0,1'b0,1'b1},1'b0};
    vecs[6] = '{1'b1,1'b0,1'b1,1'b0,1'b1,1'b1,32'h103,32'h90,5'd6,
                '{1'b0,5'd6,32'h103,1'b1,1'b0},1'b1};

    bus.dmem_ack = 1'b0;
    bus.dmem_rdata = '0;
    repeat (3) step();
    chk("rst_ex_ready", 32'(ex_ready), 32'd1);
    chk("rst_dmem_req", 32'(bus.dmem_req), 32'd0);
    rst = 1'b0;
    step();
    chk("reset_wb_valid", 32'(wb_valid), 32'd0);
    chk("reset_pc_src", 32'(pc_src), 32'd0);
    chk("reset_mem_err", 32'(mem_err), 32'd0);
    chk("reset_wb_data", wb_data, 32'h0);
    chk("reset_ex_ready", 32'(ex_ready), 32'd1);

    // Single-cycle instructions issued back to back.
    for (int i = 0; i < 7; i++) begin
      drive(vecs[i].br, vecs[i].mr, vecs[i].mw, vecs[i].m2r, vecs[i].rw, vecs[i].zero,
            vecs[i].alu, vecs[i].pcb, 32'h0, vecs[i].wr);
      push(vecs[i].e.rw, vecs[i].e.wr, vecs[i].e.data, vecs[i].e.chk_data, vecs[i].e.err);
      step();
      chk($sformatf("v%0d_wb_valid", i), 32'(wb_valid), 32'd1);
      chk($sformatf("v%0d_pc_src", i), 32'(pc_src), 32'(vecs[i].e_pcsrc));
      if (vecs[i].e_pcsrc) chk($sformatf("v%0d_pc_target", i), pc_target, vecs[i].pcb);
      chk($sformatf("v%0d_dmem_req", i), 32'(bus.dmem_req), 32'd0);
      chk($sformatf("v%0d_ex_ready", i), 32'(ex_ready), 32'd1);
    end
    ex_valid = 1'b0;
    step();
    chk("idle_wb_valid", 32'(wb_valid), 32'd0);
    chk("idle_pc_src", 32'(pc_src), 32'd0);

    // Ack while idle is ignored.
    bus.dmem_ack = 1'b1;
    step();
    bus.dmem_ack = 1'b0;
    chk("stray_ack_wb_valid", 32'(wb_valid), 32'd0);

    // Load at 0x100, ack in the third ACCESS cycle.
    drive(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 32'h100, 32'h0, 32'h0, 5'd9);
    push(1'b1, 5'd9, 32'hDEADBEEF, 1'b1, 1'b0);
    step();
    ex_valid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      chk($sformatf("ld_req_c%0d", c), 32'(bus.dmem_req), 32'd1);
      chk($sformatf("ld_we_c%0d", c), 32'(bus.dmem_we), 32'd0);
      chk($sformatf("ld_addr_c%0d", c), bus.dmem_addr, 32'h100);
      chk($sformatf("ld_ex_ready_c%0d", c), 32'(ex_ready), 32'd0);
      if (c == 2) begin
        bus.dmem_ack = 1'b1;
        bus.dmem_rdata = 32'hDEADBEEF;
      end
      step();
    end
    bus.dmem_ack = 1'b0;
    chk("ld_done_req", 32'(bus.dmem_req), 32'd0);
    chk("ld_done_ex_ready", 32'(ex_ready), 32'd1);
    chk("ld_done_wb_valid", 32'(wb_valid), 32'd1);

    // Zero-wait store at 0x104.
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h104, 32'h0, 32'hCAFEF00D, 5'd4);
    push(1'b0, 5'd4, 32'h0, 1'b0, 1'b0);
    step();
    ex_valid = 1'b0;
    chk("st_we", 32'(bus.dmem_we), 32'd1);
    chk("st_wdata", bus.dmem_wdata, 32'hCAFEF00D);
    chk("st_addr", bus.dmem_addr, 32'h104);
    chk("st_ex_ready", 32'(ex_ready), 32'd0);
    bus.dmem_ack = 1'b1;
    step();
    bus.dmem_ack = 1'b0;
    chk("st_done_ex_ready", 32'(ex_ready), 32'd1);
    chk("st_done_wb_valid", 32'(wb_valid), 32'd1);

    // Zero-wait load with mem_to_reg=0 writes back the address.
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h108, 32'h0, 32'h0, 5'd10);
    push(1'b1, 5'd10, 32'h108, 1'b1, 1'b0);
    step();
    ex_valid = 1'b0;
    bus.dmem_ack = 1'b1;
    bus.dmem_rdata = 32'h11111111;
    step();
    bus.dmem_ack = 1'b0;

    // Load with no ack times out after 4 cycles.
    drive(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 32'h200, 32'h0, 32'h0, 5'd11);
    push(1'b0, 5'd11, 32'h0, 1'b0, 1'b1);
    step();
    ex_valid = 1'b0;
    for (int c = 0; c < 4; c++) begin
      chk($sformatf("to_req_c%0d", c), 32'(bus.dmem_req), 32'd1);
      step();
    end
    chk("to_done_req", 32'(bus.dmem_req), 32'd0);
    chk("to_done_ex_ready", 32'(ex_ready), 32'd1);
    chk("to_mem_err", 32'(mem_err), 32'd1);
    step();
    chk("to_mem_err_pulse", 32'(mem_err), 32'd0);

    // Ack in the timeout cycle wins.
    drive(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 32'h300, 32'h0, 32'h0, 5'd12);
    push(1'b1, 5'd12, 32'hA5A5A5A5, 1'b1, 1'b0);
    step();
    ex_valid = 1'b0;
    repeat (3) step();
    chk("race_req", 32'(bus.dmem_req), 32'd1);
    bus.dmem_ack = 1'b1;
    bus.dmem_rdata = 32'hA5A5A5A5;
    step();
    bus.dmem_ack = 1'b0;
    chk("race_wb_valid", 32'(wb_valid), 32'd1);

    // Reset in the second ACCESS cycle abandons the request.
    drive(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 32'h400, 32'h0, 32'h0, 5'd13);
    step();
    ex_valid = 1'b0;
    step();
    chk("rstacc_req_before", 32'(bus.dmem_req), 32'd1);
    rst = 1'b1;
    #1;
    chk("rstacc_req_async", 32'(bus.dmem_req), 32'd0);
    step();
    rst = 1'b0;
    chk("rstacc_ex_ready", 32'(ex_ready), 32'd1);
    repeat (3) step();
    chk("rstacc_no_wb", 32'(wb_valid), 32'd0);
    chk("rstacc_req_idle", 32'(bus.dmem_req), 32'd0);

    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access stage of the MIPS datapath, fed directly by the execute stage. It captures the execute results (ALU result, zero flag, branch target, store data, destination register) together with their control bits and resolves taken branches. It performs loads and stores over a variable-latency req/ack data-memory port and delivers one registered write-back beat per instruction to the register file. While a memory access is outstanding it back-pressures execute.

## Interface
- TIMEOUT, 16: maximum cycles spent in ACCESS waiting for `dmem_ack` before aborting; legal range 1..255.
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- ex_valid  in  1  execute presents an instruction this cycle.
- ex_ready  out  1  stage accepts the instruction this cycle; equals (state==IDLE).
- branch, mem_read, mem_write, mem_to_reg, reg_write  in  1 each  control bits for the presented instruction.
- alu_res  in  32  ALU result; also the memory byte address.
- alu_zero  in  1  ALU zero flag.
- pc_branch  in  32  branch target computed in execute.
- rt_data  in  32  store data.
- write_reg  in  5  destination register.
- dmem_req  out  1  memory request, held until ack or timeout.
- dmem_we  out  1  1 = store, 0 = load; stable while `dmem_req`=1.
- dmem_addr  out  32  word-aligned address; stable while `dmem_req`=1.
- dmem_wdata  out  32  store data; stable while `dmem_req`=1.
- dmem_rdata  in  32  load data, valid when `dmem_ack`=1.
- dmem_ack  in  1  completes the request in the same cycle.
- pc_src  out  1  one-cycle pulse: a taken branch is being redirected.
- pc_target  out  32  redirect target, valid with `pc_src`.
- wb_valid  out  1  one-cycle pulse per retired instruction.
- wb_reg_write  out  1  register-file write enable.
- wb_write_reg  out  5  register-file write index.
- wb_data  out  32  register-file write data.
- mem_err  out  1  one-cycle pulse with `wb_valid`: misaligned access or timeout.

## Operation
- Instruction types:
  - Branch: `branch`=1. The mem bits are ignored.
  - Memory op: `branch`=0 and (`mem_read` or `mem_write`). If both are set, `mem_write` wins.
  - Plain: all other instructions.
- Accept: an instruction is accepted on a rising edge where `ex_valid` and `ex_ready` are both 1. `ex_valid` while `ex_ready`=0 is ignored; execute must hold its outputs.
- FSM states: IDLE, ACCESS.
  - IDLE, accepting a plain or branch instruction: stay in IDLE and load the write-back registers at the same edge.
    - `wb_data` = `alu_res`.
    - `wb_reg_write` = `reg_write` & !`branch`.
    - `pc_src` = `branch` & `alu_zero`; `pc_target` = `pc_branch`.
  - IDLE, accepting a memory op with `alu_res[1:0]`≠0: no request is issued. Emit `wb_valid` with `wb_reg_write`=0 and `mem_err`=1; stay in IDLE.
  - IDLE, accepting an aligned memory op: latch the address, data, we, `mem_to_reg`, `reg_write` and `write_reg`. Clear the wait counter and go to ACCESS.
  - ACCESS: `dmem_req`=1 and the counter increments each cycle.
    - On an edge with `dmem_ack`=1:
      - Load: `wb_data` = `mem_to_reg` ? `dmem_rdata` : address, and `wb_reg_write` = latched `reg_write`.
      - Store: `wb_reg_write`=0.
      - Then go to IDLE.
    - Timeout: if the counter reaches TIMEOUT-1 with no ack, go to IDLE and emit `wb_valid` with `wb_reg_write`=0 and `mem_err`=1. An ack arriving in that same cycle takes priority over the timeout.
- `wb_reg_write` is forced to 0 whenever `wb_write_reg`=0.
- `dmem_ack` outside ACCESS is ignored.

## Timing
- Reset values:
  - State is IDLE and the counter is 0.
  - All outputs are 0, except `ex_ready`=1.
  - `dmem_req` drops asynchronously with `rst`.
- Reset during ACCESS abandons the request; no write-back is produced.
- Latency:
  - Plain, branch and misaligned instructions: `wb_valid` and `pc_src` are high in the cycle after the accept edge.
  - Aligned memory op: `dmem_req` is high from the cycle after accept. `wb_valid` is high in the cycle after the ack edge.
  - Zero-wait memory (ack in the first ACCESS cycle): 2 cycles from accept to `wb_valid`, and `ex_ready`=0 for exactly 1 cycle.
- Pulse widths:
  - `wb_valid`, `pc_src` and `mem_err` are high for one cycle.
  - `wb_data`, `wb_write_reg` and `pc_target` hold their values until the next load.
- Throughput: back-to-back plain instructions retire one per cycle.

## Test plan
- Plain op: `alu_res`=0x1234, `write_reg`=5, `reg_write`=1 -> next cycle `wb_valid`=1, `wb_reg_write`=1, `wb_write_reg`=5, `wb_data`=0x1234. `write_reg`=0 -> `wb_reg_write`=0.
- Branch: `alu_zero`=1, `pc_branch`=0x40 -> one-cycle `pc_src`=1, `pc_target`=0x40, `wb_reg_write`=0. `alu_zero`=0 -> `pc_src` stays 0.
- Load at 0x100 with ack after 3 ACCESS cycles, `dmem_rdata`=0xDEADBEEF, `mem_to_reg`=1 -> address and we stable for 3 cycles, `ex_ready`=0 throughout, then `wb_data`=0xDEADBEEF. Store at 0x104 -> `dmem_we`=1, `dmem_wdata`=`rt_data`, `wb_reg_write`=0.
- Misaligned store at 0x102 -> no `dmem_req`; next cycle `wb_valid`=1, `mem_err`=1. Load with no ack and TIMEOUT=4 -> `dmem_req` high for 4 cycles, then `mem_err` pulse and return to IDLE.
- `rst` asserted in the 2nd ACCESS cycle -> `dmem_req` low immediately, no `wb_valid`, `ex_ready`=1 after release. Ack in the same cycle as timeout -> normal write-back, `mem_err`=0.
